cpu_param: RTL and testbench
============================

CPU_PARAM -- requirements
Module: cpu_param

Interface
- REQ-001 Parameter WIDTH, default 4: datapath width of registers X, Y, Z and of the ULA.
- REQ-002 Parameter DEPTH, default 16: program memory words; PC_W = ceil(log2(DEPTH)); WIDTH >= PC_W required, elaboration error otherwise.
- REQ-003 clock  in  1  single rising-edge clock for all state.
- REQ-004 reset_n  in  1  synchronous, active-low reset.
- REQ-005 run  in  1  start/restart request, sampled each edge.
- REQ-006 prog_we  in  1  program memory write enable.
- REQ-007 prog_addr  in  PC_W  program write address.
- REQ-008 prog_data  in  14+WIDTH  instruction word: [13+WIDTH:14]=imm, [13:12]=op, [11:9]=Tx, [8:6]=Ty, [5:3]=Tz, [2:0]=Tula.
- REQ-009 outX, outY, outZ  out  WIDTH each  register contents.
- REQ-010 outULA  out  WIDTH  combinational ULA result from current outX, outY and the Tula field of the current instruction.
- REQ-011 pc  out  PC_W  address of the instruction being executed.
- REQ-012 halted  out  1  high in state HALT.
- REQ-013 zero, carry  out  1 each  registered ULA flags.

Function
- REQ-014 The FSM has states IDLE, RUN and HALT.
- REQ-015 Program memory shall be written on prog_we only in IDLE; prog_we in RUN or HALT shall be ignored; memory read shall be combinational at pc.
- REQ-016 IDLE: pc=0; run=1 -> RUN. A prog_we in the same cycle shall still write, and the word shall be visible to the first RUN cycle.
- REQ-017 RUN executes one instruction per cycle by op: 00 EXEC, 01 JMPZ, 10 JMP, 11 HALT.
- REQ-018 EXEC: X, Y, Z update per Tx, Ty, Tz; zero <= (outULA==0); carry <= ULA carry; pc <= pc+1, wrapping DEPTH-1 -> 0.
- REQ-019 JMPZ: pc <= imm[PC_W-1:0] if zero=1, else pc+1. JMP: pc <= imm[PC_W-1:0]. Registers and flags hold for both.
- REQ-020 HALT op: state <= HALT; pc, registers and flags hold.
- REQ-021 HALT: run=1 -> RUN with pc=0; registers, flags and memory are kept.
- REQ-022 Register function codes (Tx/Ty/Tz): 000 hold, 001 load, 010 clear, 011 logical shift left, 100 logical shift right (zero fill), 101 increment, 110 decrement, 111 load outULA. Increment and decrement wrap modulo 2^WIDTH.
- REQ-023 Load source for code 001: X from imm, Y from outULA, Z from outY.
- REQ-024 All register updates in one cycle shall use pre-edge values, e.g. Z loads the old Y.
- REQ-025 Tula codes: 000 X+Y, 001 X-Y, 010 X&Y, 011 X|Y, 100 X^Y, 101 ~X, 110 pass X, 111 pass Y. Results are truncated to WIDTH bits.
- REQ-026 carry = carry-out for add, borrow (X<Y) for sub, 0 for all other codes.
- REQ-027 Registers change only on EXEC cycles in RUN; in IDLE and HALT they hold.

Reset
- REQ-028 reset_n=0 at an edge shall set: state IDLE, pc=0, X=Y=Z=0, zero=carry=0, halted=0. This applies mid-run as well.
- REQ-029 Reset shall not alter program memory; contents after power-up are undefined until written.

Verification (WIDTH=4, DEPTH=16)
- V1 Reset: reset_n=0 for one edge from any state -> all outputs 0, halted=0; run=0 keeps IDLE and pc=0.
- V2 Load/move: program [0] Tx=001 imm=5; [1] Tula=000, Ty=111; [2] Tz=001; [3] HALT; then pulse run -> X=5, Y=5, Z=5, halted=1, pc=3, 4 cycles after RUN entry.
- V3 Overflow: X=9, Y=9, EXEC with Tula=000 -> outULA=2, carry=1, zero=0. With Tula=001 -> outULA=0, zero=1, carry=0.
- V4 Loop and wrap: [0] X=imm 3; [1] Tx=110, Tula=110; [2] JMPZ 4; [3] JMP 1; [4] HALT -> body runs 4 times, final X=15, zero=1, halted=1, pc=4.
- V5 Reset mid-run: assert reset_n=0 during the V4 loop, then pulse run -> program reruns from pc=0 unchanged, same final state as V4.
- V6 Write protection: prog_we to address 0 during RUN -> no effect. HALT then run -> restart at pc=0 with registers retained (X=15 before the first EXEC).

Source files
------------

// File: rtl/cpu_param.sv
// cpu_param: three-register CPU (X, Y, Z) with a small ALU and on-chip program memory.
// Executes one instruction per cycle; the program is loaded only while idle.
module cpu_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned IW   = 14 + WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             prog_we,
  input  logic [PC_W-1:0]  prog_addr,
  input  logic [IW-1:0]    prog_data,
  output logic [WIDTH-1:0] outX,
  output logic [WIDTH-1:0] outY,
  output logic [WIDTH-1:0] outZ,
  output logic [WIDTH-1:0] outULA,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             zero,
  output logic             carry
);

  if (WIDTH < PC_W) begin : g_width_check
    $error("cpu_param: WIDTH must be >= PC_W so imm can address program memory");
  end

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [WIDTH-1:0] OneW  = WIDTH'(1);
  localparam logic [PC_W-1:0]  OnePc = PC_W'(1);
  localparam logic [PC_W-1:0]  LastPc = PC_W'(DEPTH - 1);

  logic [IW-1:0]    r_mem [DEPTH];
  state_e           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_inc, w_jmp;
  logic [WIDTH-1:0] r_x, r_y, r_z, w_x_nxt, w_y_nxt, w_z_nxt;
  logic             r_zero, r_carry, w_zero_nxt, w_carry_nxt;

  logic [IW-1:0]    w_instr;
  logic [WIDTH-1:0] w_imm, w_ula;
  logic [1:0]       w_op;
  logic [2:0]       w_tx, w_ty, w_tz, w_tula;
  logic             w_ula_c;

  assign w_instr = r_mem[r_pc];
  assign w_imm   = w_instr[13+WIDTH:14];
  assign w_op    = w_instr[13:12];
  assign w_tx    = w_instr[11:9];
  assign w_ty    = w_instr[8:6];
  assign w_tz    = w_instr[5:3];
  assign w_tula  = w_instr[2:0];
  assign w_jmp   = w_imm[PC_W-1:0];
  assign w_pc_inc = (r_pc == LastPc) ? '0 : r_pc + OnePc;

  // Memory is deliberately outside the reset domain: reset must not disturb the program.
  always_ff @(posedge clock) begin
    if (prog_we && (r_state == StIdle)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    w_ula   = '0;
    w_ula_c = 1'b0;
    unique case (w_tula)
      3'b000: {w_ula_c, w_ula} = {1'b0, r_x} + {1'b0, r_y};
      3'b001: begin
        w_ula   = r_x - r_y;
        w_ula_c = (r_x < r_y);
      end
      3'b010: w_ula = r_x & r_y;
      3'b011: w_ula = r_x | r_y;
      3'b100: w_ula = r_x ^ r_y;
      3'b101: w_ula = ~r_x;
      3'b110: w_ula = r_x;
      3'b111: w_ula = r_y;
    endcase
  end

  function automatic logic [WIDTH-1:0] f_reg(input logic [2:0]       code,
                                             input logic [WIDTH-1:0] cur,
                                             input logic [WIDTH-1:0] ld,
                                             input logic [WIDTH-1:0] ula);
    logic [WIDTH-1:0] res;
    unique case (code)
      3'b000: res = cur;
      3'b001: res = ld;
      3'b010: res = '0;
      3'b011: res = cur << 1;
      3'b100: res = cur >> 1;
      3'b101: res = cur + OneW;
      3'b110: res = cur - OneW;
      3'b111: res = ula;
    endcase
    return res;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_z_nxt     = r_z;
    w_zero_nxt  = r_zero;
    w_carry_nxt = r_carry;
    unique case (r_state)
      StIdle: begin
        w_pc_nxt = '0;
        if (run) w_state_nxt = StRun;
      end
      StRun: begin
        unique case (w_op)
          2'b00: begin
            // All sources are pre-edge values, so Z takes the old Y.
            w_x_nxt     = f_reg(w_tx, r_x, w_imm, w_ula);
            w_y_nxt     = f_reg(w_ty, r_y, w_ula, w_ula);
            w_z_nxt     = f_reg(w_tz, r_z, r_y, w_ula);
            w_zero_nxt  = (w_ula == '0);
            w_carry_nxt = w_ula_c;
            w_pc_nxt    = w_pc_inc;
          end
          2'b01: w_pc_nxt = r_zero ? w_jmp : w_pc_inc;
          2'b10: w_pc_nxt = w_jmp;
          2'b11: w_state_nxt = StHalt;
        endcase
      end
      StHalt: begin
        if (run) begin
          w_state_nxt = StRun;
          w_pc_nxt    = '0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_z     <= w_z_nxt;
      r_zero  <= w_zero_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign outX   = r_x;
  assign outY   = r_y;
  assign outZ   = r_z;
  assign outULA = w_ula;
  assign pc     = r_pc;
  assign halted = (r_state == StHalt);
  assign zero   = r_zero;
  assign carry  = r_carry;

endmodule

// File: tb/tb_cpu_param.sv
// Scoreboarded bench for cpu_param: an instruction-level interpreter predicts every cycle,
// a negedge monitor compares; directed programs add end-state checks.
module tb_cpu_param;
  localparam int W   = 4;
  localparam int D   = 16;
  localparam int PCW = 4;
  localparam int IW  = 14 + W;
  localparam int M   = 1 << W;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           run = 1'b0;
  logic           prog_we = 1'b0;
  logic [PCW-1:0] prog_addr = '0;
  logic [IW-1:0]  prog_data = '0;
  logic [W-1:0]   outX, outY, outZ, outULA;
  logic [PCW-1:0] pc;
  logic           halted, zero, carry;

  cpu_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .outX(outX), .outY(outY),
    .outZ(outZ), .outULA(outULA), .pc(pc), .halted(halted), .zero(zero), .carry(carry)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x, y, z, ula, pc;
    bit ula_ok, halted, zero, carry;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: 0 idle, 1 run, 2 halt.
  int m_mem[D];
  bit m_ok[D];
  int m_st = 0;
  int m_x = 0, m_y = 0, m_z = 0, m_pc = 0;
  bit m_zf = 0, m_cf = 0;
  int p[D];

  function automatic void m_alu(input int x, input int y, input int t,
                                output int res, output bit c);
    c = 0;
    case (t)
      0: begin res = (x + y) % M; c = (x + y) >= M; end
      1: begin res = (x - y + M) % M; c = x < y; end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: res = M - 1 - x;
      6: res = x;
      default: res = y;
    endcase
  endfunction

  function automatic int m_reg(input int code, input int cur, input int ld, input int ula);
    case (code)
      0: return cur;
      1: return ld;
      2: return 0;
      3: return (cur * 2) % M;
      4: return cur / 2;
      5: return (cur + 1) % M;
      6: return (cur + M - 1) % M;
      default: return ula;
    endcase
  endfunction

  function automatic void m_step(input bit rn, input bit r, input bit we, input int a,
                                 input int d);
    int w, imm, op, ula;
    bit c;
    if (m_st == 0 && we) begin
      m_mem[a] = d;
      m_ok[a]  = 1;
    end
    if (!rn) begin
      m_st = 0; m_pc = 0; m_x = 0; m_y = 0; m_z = 0; m_zf = 0; m_cf = 0;
    end else if (m_st == 0) begin
      if (r) m_st = 1;
    end else if (m_st == 2) begin
      if (r) begin m_st = 1; m_pc = 0; end
    end else begin
      w   = m_mem[m_pc];
      imm = w / 16384;
      op  = (w / 4096) % 4;
      if (op == 0) begin
        m_alu(m_x, m_y, w % 8, ula, c);
        begin
          int nx, ny, nz;
          nx = m_reg((w / 512) % 8, m_x, imm, ula);
          ny = m_reg((w / 64) % 8, m_y, ula, ula);
          nz = m_reg((w / 8) % 8, m_z, m_y, ula);
          m_x = nx; m_y = ny; m_z = nz;
        end
        m_zf = (ula == 0);
        m_cf = c;
        m_pc = (m_pc + 1) % D;
      end else if (op == 1) begin
        m_pc = m_zf ? imm % D : (m_pc + 1) % D;
      end else if (op == 2) begin
        m_pc = imm % D;
      end else begin
        m_st = 2;
      end
    end
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    bit   c;
    e.x = m_x; e.y = m_y; e.z = m_z; e.pc = m_pc;
    e.halted = (m_st == 2); e.zero = m_zf; e.carry = m_cf;
    e.ula_ok = m_ok[m_pc];
    e.ula = 0;
    if (e.ula_ok) m_alu(m_x, m_y, m_mem[m_pc] % 8, e.ula, c);
    return e;
  endfunction

  function automatic int mk(input int imm, input int op, input int tx, input int ty,
                            input int tz, input int tula);
    return imm * 16384 + op * 4096 + tx * 512 + ty * 64 + tz * 8 + tula;
  endfunction

  // Monitor: DUT state is presented every cycle; compare on the falling edge.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (int'(outX) != e.x || int'(outY) != e.y || int'(outZ) != e.z ||
          int'(pc) != e.pc || halted != e.halted || zero != e.zero || carry != e.carry ||
          (e.ula_ok && int'(outULA) != e.ula)) begin
        n_bad++;
        $display("FAIL cycle@%0t: got X=%0d Y=%0d Z=%0d ULA=%0d pc=%0d h=%0b z=%0b c=%0b, required X=%0d Y=%0d Z=%0d ULA=%0d(chk %0b) pc=%0d h=%0b z=%0b c=%0b",
                 $time, outX, outY, outZ, outULA, pc, halted, zero, carry,
                 e.x, e.y, e.z, e.ula, e.ula_ok, e.pc, e.halted, e.zero, e.carry);
      end
    end
  end

  task automatic step(input bit rn, input bit r, input bit we, input int a, input int d);
    reset_n   = rn;
    run       = r;
    prog_we   = we;
    prog_addr = a[PCW-1:0];
    prog_data = d[IW-1:0];
    @(posedge clock);
    m_step(rn, r, we, a, d);
    q.push_back(m_expect());
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reset, write p[0..n-1], then pulse run so the next cycle is the first RUN cycle.
  task automatic load(input int n);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(1, 0, 1, i, p[i]);
    step(1, 1, 0, 0, 0);
  endtask

  task automatic run_to_halt(input string name, input int max, output int cyc,
                             output int body);
    cyc  = 0;
    body = 0;
    while (!halted && cyc < max) begin
      step(1, 0, 0, 0, 0);
      cyc++;
      if (pc == 4'd1 && !halted) body++;
    end
    if (!halted) chk({name, " halt timeout"}, 0, 1);
  endtask

  task automatic chk_v4(input string name, input int body);
    chk({name, " body count"}, body, 4);
    chk({name, " X"}, int'(outX), 15);
    chk({name, " zero"}, int'(zero), 1);
    chk({name, " halted"}, int'(halted), 1);
    chk({name, " pc"}, int'(pc), 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, body;

    // V1 from power-up
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("V1 idle pc", int'(pc), 0);
    chk("V1 idle halted", int'(halted), 0);

    // V2 load/move
    p[0] = mk(5, 0, 1, 0, 0, 0);
    p[1] = mk(0, 0, 0, 7, 0, 0);
    p[2] = mk(0, 0, 0, 0, 1, 0);
    p[3] = mk(0, 3, 0, 0, 0, 0);
    load(4);
    run_to_halt("V2", 20, cyc, body);
    chk("V2 cycles", cyc, 4);
    chk("V2 X", int'(outX), 5);
    chk("V2 Y", int'(outY), 5);
    chk("V2 Z", int'(outZ), 5);
    chk("V2 pc", int'(pc), 3);

    // V1 reset from HALT
    step(0, 0, 0, 0, 0);
    chk("V1 X", int'(outX), 0);
    chk("V1 halted", int'(halted), 0);
    chk("V1 pc", int'(pc), 0);

    // V3 overflow and subtract-to-zero
    p[0] = mk(9, 0, 1, 0, 0, 0);
    p[1] = mk(0, 0, 0, 7, 0, 6);
    p[2] = mk(0, 0, 0, 0, 0, 0);
    p[3] = mk(0, 0, 0, 0, 0, 1);
    p[4] = mk(0, 3, 0, 0, 0, 0);
    load(5);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("V3 add ULA", int'(outULA), 2);
    step(1, 0, 0, 0, 0);
    chk("V3 add carry", int'(carry), 1);
    chk("V3 add zero", int'(zero), 0);
    chk("V3 sub ULA", int'(outULA), 0);
    step(1, 0, 0, 0, 0);
    chk("V3 sub zero", int'(zero), 1);
    chk("V3 sub carry", int'(carry), 0);

    // V4 countdown loop with wrap
    p[0] = mk(3, 0, 1, 0, 0, 0);
    p[1] = mk(0, 0, 6, 0, 0, 6);
    p[2] = mk(4, 1, 0, 0, 0, 0);
    p[3] = mk(1, 2, 0, 0, 0, 0);
    p[4] = mk(0, 3, 0, 0, 0, 0);
    load(5);
    run_to_halt("V4", 60, cyc, body);
    chk_v4("V4", body);

    // V5 reset mid-loop, rerun without reloading
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("V5 reset X", int'(outX), 0);
    chk("V5 reset pc", int'(pc), 0);
    step(1, 1, 0, 0, 0);
    run_to_halt("V5", 60, cyc, body);
    chk_v4("V5", body);

    // V6 writes ignored outside IDLE; restart from HALT keeps registers
    step(1, 1, 0, 0, 0);
    chk("V6 restart pc", int'(pc), 0);
    chk("V6 restart X", int'(outX), 15);
    step(1, 0, 1, 0, mk(0, 3, 0, 0, 0, 0));
    run_to_halt("V6", 60, cyc, body);
    step(1, 0, 1, 0, mk(0, 3, 0, 0, 0, 0));
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("V6 protected pc", int'(pc), 1);
    chk("V6 protected X", int'(outX), 3);

    // Randomized programs with stray run/we/reset pulses
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < D; i++) begin
        int r;
        r = $urandom_range(0, 9);
        p[i] = mk($urandom_range(0, M - 1), (r < 7) ? 0 : r - 6, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      load(D);
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, D - 1),
             $urandom_range(0, (1 << IW) - 1));
      end
    end

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
